// File: rtl/fuec_decoder_48_32.sv
// Two-stage SEC-DED decoder for a 48-bit codeword (32 data + 16 check bits).
// Optional macro FUEC_OUT_REG_EN adds the stage-2 output registers (latency 2, else 1).
module fuec_decoder_48_32 (
    input  logic        clk,
    input  logic        rst,
    input  logic [47:0] r,
    output logic [15:0] s,
    output logic [47:0] r_fix,
    output logic [47:0] pos_error,
    output logic        no_error,
    output logic        corrected,
    output logic        uncorrectable
);

    // 4-bit index arithmetic wraps naturally, giving the mod-16 rotations of H.
    function automatic logic [15:0] h_col(input int unsigned c);
        logic [15:0] col;
        logic [3:0]  b;
        col = '0;
        b   = 4'(c);
        if (c < 16) begin
            col[b]         = 1'b1;
            col[b + 4'd1]  = 1'b1;
            col[b + 4'd3]  = 1'b1;
        end else if (c < 32) begin
            col[b]         = 1'b1;
            col[b + 4'd2]  = 1'b1;
            col[b + 4'd7]  = 1'b1;
        end else begin
            col[b]         = 1'b1;
        end
        return col;
    endfunction

    logic [15:0] s_in;
    logic [47:0] r1_q;
    logic [15:0] s1_q;
    logic        v1_q;

    logic [47:0] pos_d;
    logic [47:0] fix_d;
    logic        ne_d;
    logic        cor_d;
    logic        unc_d;

    always_comb begin
        s_in = '0;
        for (int c = 0; c < 48; c++) begin
            if (r[c]) begin
                s_in = s_in ^ h_col(c);
            end
        end
    end

    // v1_q keeps the flags low while stage 1 holds reset contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            r1_q <= '0;
            s1_q <= '0;
            v1_q <= 1'b0;
        end else begin
            r1_q <= r;
            s1_q <= s_in;
            v1_q <= 1'b1;
        end
    end

    // Columns are distinct, so at most one bit of pos_d can be set.
    always_comb begin
        pos_d = '0;
        for (int c = 0; c < 48; c++) begin
            if (s1_q == h_col(c)) begin
                pos_d[c] = 1'b1;
            end
        end
        fix_d = r1_q ^ pos_d;
        ne_d  = v1_q && (s1_q == '0);
        cor_d = v1_q && (|pos_d);
        unc_d = v1_q && (s1_q != '0) && !(|pos_d);
    end

`ifdef FUEC_OUT_REG_EN
    logic [15:0] s2_q;
    logic [47:0] fix2_q;
    logic [47:0] pos2_q;
    logic        ne2_q;
    logic        cor2_q;
    logic        unc2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_q   <= '0;
            fix2_q <= '0;
            pos2_q <= '0;
            ne2_q  <= 1'b0;
            cor2_q <= 1'b0;
            unc2_q <= 1'b0;
        end else begin
            s2_q   <= s1_q;
            fix2_q <= fix_d;
            pos2_q <= pos_d;
            ne2_q  <= ne_d;
            cor2_q <= cor_d;
            unc2_q <= unc_d;
        end
    end

    assign s             = s2_q;
    assign r_fix         = fix2_q;
    assign pos_error     = pos2_q;
    assign no_error      = ne2_q;
    assign corrected     = cor2_q;
    assign uncorrectable = unc2_q;
`else
    assign s             = s1_q;
    assign r_fix         = fix_d;
    assign pos_error     = pos_d;
    assign no_error      = ne_d;
    assign corrected     = cor_d;
    assign uncorrectable = unc_d;
`endif

endmodule

// File: tb/tb_fuec_decoder_48_32.sv
// Directed self-checking bench for fuec_decoder_48_32; latency follows FUEC_OUT_REG_EN.
module tb_fuec_decoder_48_32;

`ifdef FUEC_OUT_REG_EN
    localparam int Lat = 2;
`else
    localparam int Lat = 1;
`endif
    localparam int N = 11;

    logic        clk;
    logic        rst;
    logic [47:0] r;
    logic [15:0] s;
    logic [47:0] r_fix;
    logic [47:0] pos_error;
    logic        no_error;
    logic        corrected;
    logic        uncorrectable;

    int n_assert;
    int n_fail;

    logic [47:0] vr   [N];
    logic [15:0] vs   [N];
    logic [47:0] vfix [N];
    logic [47:0] vpos [N];
    logic [2:0]  vflg [N];

    fuec_decoder_48_32 dut (
        .clk           (clk),
        .rst           (rst),
        .r             (r),
        .s             (s),
        .r_fix         (r_fix),
        .pos_error     (pos_error),
        .no_error      (no_error),
        .corrected     (corrected),
        .uncorrectable (uncorrectable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_out(input string tag, input logic [15:0] es, input logic [47:0] efix,
                             input logic [47:0] epos, input logic [2:0] eflg);
        logic [2:0] flg;
        flg = {no_error, corrected, uncorrectable};
        n_assert++;
        assert (s === es) else begin
            n_fail++;
            $error("FAIL %s.s: observed %h expected %h", tag, s, es);
        end
        n_assert++;
        assert (r_fix === efix) else begin
            n_fail++;
            $error("FAIL %s.r_fix: observed %h expected %h", tag, r_fix, efix);
        end
        n_assert++;
        assert (pos_error === epos) else begin
            n_fail++;
            $error("FAIL %s.pos_error: observed %h expected %h", tag, pos_error, epos);
        end
        n_assert++;
        assert (flg === eflg) else begin
            n_fail++;
            $error("FAIL %s.flags{ne,cor,unc}: observed %b expected %b", tag, flg, eflg);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;

        // r, syndrome, corrected word, error position, flags {no_error, corrected, uncorrectable}
        vr[0]  = 48'h0;              vs[0]  = 16'h0000; vfix[0]  = 48'h0;
        vpos[0]  = 48'h0;              vflg[0]  = 3'b100;
        vr[1]  = 48'h1;              vs[1]  = 16'h000B; vfix[1]  = 48'h0;
        vpos[1]  = 48'h1;              vflg[1]  = 3'b010;
        vr[2]  = 48'h2;              vs[2]  = 16'h0016; vfix[2]  = 48'h0;
        vpos[2]  = 48'h2;              vflg[2]  = 3'b010;
        vr[3]  = 48'h0001_0000_0000; vs[3]  = 16'h0001; vfix[3]  = 48'h0;
        vpos[3]  = 48'h0001_0000_0000; vflg[3]  = 3'b010;
        vr[4]  = 48'hFFFF_FFFF_FFFF; vs[4]  = 16'hFFFF; vfix[4]  = 48'hFFFF_FFFF_FFFF;
        vpos[4]  = 48'h0;              vflg[4]  = 3'b001;
        vr[5]  = 48'h3;              vs[5]  = 16'h001D; vfix[5]  = 48'h3;
        vpos[5]  = 48'h0;              vflg[5]  = 3'b001;
        vr[6]  = 48'h0000_0001_0000; vs[6]  = 16'h0085; vfix[6]  = 48'h0;
        vpos[6]  = 48'h0000_0001_0000; vflg[6]  = 3'b010;
        vr[7]  = 48'h0000_8000_0000; vs[7]  = 16'h8042; vfix[7]  = 48'h0;
        vpos[7]  = 48'h0000_8000_0000; vflg[7]  = 3'b010;
        vr[8]  = 48'h8000_0000_0000; vs[8]  = 16'h8000; vfix[8]  = 48'h0;
        vpos[8]  = 48'h8000_0000_0000; vflg[8]  = 3'b010;
        vr[9]  = 48'h000B_0000_0001; vs[9]  = 16'h0000; vfix[9]  = 48'h000B_0000_0001;
        vpos[9]  = 48'h0;              vflg[9]  = 3'b100;
        vr[10] = 48'h000B_0000_0000; vs[10] = 16'h000B; vfix[10] = 48'h000B_0000_0001;
        vpos[10] = 48'h1;              vflg[10] = 3'b010;

        // Reset with junk on the input: everything must read zero.
        rst = 1'b1;
        r   = 48'hDEAD_BEEF_1234;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 16'h0, 48'h0, 48'h0, 3'b000);
        rst = 1'b0;

        // Back-to-back vectors, one per cycle; each result appears Lat edges later.
        for (int c = 0; c < N + Lat - 1; c++) begin
            r = (c < N) ? vr[c] : 48'h0;
            @(posedge clk);
            #1;
            if (c >= Lat - 1) begin
                check_out($sformatf("vec%0d", c - Lat + 1), vs[c - Lat + 1], vfix[c - Lat + 1],
                          vpos[c - Lat + 1], vflg[c - Lat + 1]);
            end
        end

        // Mid-stream reset discards in-flight data.
        r = 48'hFFFF_FFFF_FFFF;
        @(posedge clk);
        #1;
        r   = 48'h1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_out("midreset", 16'h0, 48'h0, 48'h0, 3'b000);
        rst = 1'b0;
        r   = 48'h2;
        repeat (Lat) @(posedge clk);
        #1;
        check_out("after_reset", 16'h0016, 48'h0, 48'h2, 3'b010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
